br_csr_tag_alloc_ctrl: RTL
==========================

BR_CSR_TAG_ALLOC_CTRL -- requirements
Module: br_csr_tag_alloc_ctrl

Interface
REQ-001 Parameter TAGWIDE, default 4: width of a branch/CSR issue-queue tag.
REQ-002 Parameter TAGNUM, default 4: number of tags circulating through the tag free-list.
REQ-003 Clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Rest  input  1  reset; asynchronous, active-low.
REQ-005 Req0Valid, Req1Valid  input  1 each  dispatch requesters 0 and 1 ask for one tag.
REQ-006 Req0Ready, Req1Ready  output  1 each  grant to requester 0 / 1 this cycle; at most one high per cycle.
REQ-007 GntTag  output  TAGWIDE  tag granted this cycle; valid only when a Ready is high.
REQ-008 RelValid  input  1  completion returns one tag.
REQ-009 RelTag  input  TAGWIDE  tag being returned.
REQ-010 FlushReq  input  1  pipeline flush; restore free-list to its initial contents.
REQ-011 FlushBusy  output  1  high while the flush sequence is in progress.
REQ-012 FlRable  output  1  pop strobe to the free-list.
REQ-013 FlPreOut  input  TAGWIDE  free-list head entry, combinational.
REQ-014 FlEmpty, FlFull  input  1 each  free-list status.
REQ-015 FlWable  output  1  push strobe to the free-list.
REQ-016 FlDin  output  TAGWIDE  tag pushed to the free-list.
REQ-017 FlClean  output  1  free-list reinitialise strobe.
REQ-018 InFlight  output  3  count of granted, unreleased tags.
REQ-019 ErrRel  output  1  sticky illegal-release flag.

Function
REQ-020 FSM states RUN, FLUSH, SETTLE; RUN->FLUSH on FlushReq; FLUSH->SETTLE unconditionally; SETTLE->RUN unconditionally, unless FlushReq high, then SETTLE->FLUSH.
REQ-021 FlClean = 1 only in FLUSH (exactly one cycle per flush entry); FlushBusy = 1 in FLUSH and SETTLE.
REQ-022 FlushReq in RUN takes priority over same-cycle grant and release: no Ready, FlRable, or FlWable that cycle.
REQ-023 Grant eligible only in RUN with FlEmpty=0 and InFlight<TAGNUM.
REQ-024 Arbitration round-robin via 1-bit priority pointer: requester matching pointer wins if valid, else the other if valid.
REQ-025 After a grant, pointer moves to the non-granted requester; no grant leaves pointer unchanged.
REQ-026 Grant is combinational, zero latency: ReqNReady=1, FlRable=1, GntTag=FlPreOut in the same cycle.
REQ-027 Release accepted in RUN when RelValid=1, FlFull=0, and InFlight>0: FlWable=1, FlDin=RelTag the same cycle.
REQ-028 Release with FlFull=1 or InFlight=0 in RUN: FlWable suppressed, ErrRel set, held until reset.
REQ-029 Release during FLUSH or SETTLE is silently dropped (tag already reclaimed by FlClean); ErrRel unaffected.
REQ-030 Grant and accepted release in the same cycle both occur; InFlight unchanged.
REQ-031 InFlight +1 per grant, -1 per accepted release, registered; cleared to 0 in the FLUSH cycle.
REQ-032 FlDin = RelTag whenever FlWable=0 (no extra mux state); GntTag = FlPreOut always.
REQ-033 Never FlRable and FlClean in the same cycle; never FlWable and FlClean in the same cycle.

Reset
REQ-034 Rest low asynchronously forces: state RUN, pointer 0 (requester 0 first), InFlight 0, ErrRel 0.
REQ-035 During reset, all strobes (Req0Ready, Req1Ready, FlRable, FlWable, FlClean) are 0.
REQ-036 Reset assertion mid-grant or mid-flush aborts the operation with no further strobes; the free-list is reinitialised by its own reset.

Verification
REQ-037 After reset, both Req valid for 5 cycles, free-list with initial contents:
- grants R0=2, R1=6, R0=10, R1=14;
- 5th cycle no Ready (InFlight=4);
- InFlight ends 4.
REQ-038 Only Req1Valid for 2 cycles after reset -> Req1Ready both cycles; tags 2, 6; pointer ends 0.
REQ-039 InFlight=2, RelValid with RelTag=6 plus a grant in the same cycle -> FlWable=1, FlDin=6, FlRable=1; InFlight stays 2.
REQ-040 RelValid with InFlight=0 -> FlWable=0, ErrRel=1 next cycle and held.
REQ-041 FlushReq for 1 cycle while InFlight=3 and both Req valid:
- FlClean high exactly 1 cycle; FlushBusy 2 cycles; no Ready during those;
- InFlight=0;
- next grant returns tag 2.
REQ-042 Rest asserted in the FLUSH cycle -> FlClean drops immediately; after release, state RUN and grant order restarts at requester 0.

Source files
------------

// File: rtl/br_csr_tag_alloc_ctrl.sv
// br_csr_tag_alloc_ctrl
//   Hands out branch/CSR issue-queue tags from an external free-list to two
//   dispatch requesters (round-robin), returns completed tags to the list,
//   and runs a FLUSH/SETTLE sequence that reinitialises the list.
// Ports:
//   Clk, Rest                 clock, async active-low reset
//   Req0/1Valid, Req0/1Ready  tag requests / one-hot grant
//   GntTag                    granted tag (free-list head)
//   RelValid, RelTag          tag release from completion
//   FlushReq, FlushBusy       flush request / flush in progress
//   FlRable, FlWable, FlDin,
//   FlClean, FlPreOut,
//   FlEmpty, FlFull           free-list pop/push/reinit and status
//   InFlight                  granted, unreleased tag count
//   ErrRel                    sticky illegal-release flag
module br_csr_tag_alloc_ctrl #(
  parameter int unsigned TAGWIDE = 4,
  parameter int unsigned TAGNUM  = 4
) (
  input  logic               Clk,
  input  logic               Rest,
  input  logic               Req0Valid,
  input  logic               Req1Valid,
  output logic               Req0Ready,
  output logic               Req1Ready,
  output logic [TAGWIDE-1:0] GntTag,
  input  logic               RelValid,
  input  logic [TAGWIDE-1:0] RelTag,
  input  logic               FlushReq,
  output logic               FlushBusy,
  output logic               FlRable,
  input  logic [TAGWIDE-1:0] FlPreOut,
  input  logic               FlEmpty,
  input  logic               FlFull,
  output logic               FlWable,
  output logic [TAGWIDE-1:0] FlDin,
  output logic               FlClean,
  output logic [2:0]         InFlight,
  output logic               ErrRel
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    SETTLE = 2'd2
  } state_e;

  localparam logic [3:0] TAG_LIMIT = 4'(TAGNUM);

  state_e     state_q, state_d;
  logic       ptr_q, ptr_d;
  logic [2:0] inflight_q, inflight_d;
  logic       err_q, err_d;

  logic run_go, grant_ok, gnt0, gnt1, rel_ok, rel_bad;

  // State register
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      state_q    <= RUN;
      ptr_q      <= 1'b0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (FlushReq) state_d = FLUSH;
      FLUSH:   state_d = SETTLE;
      SETTLE:  state_d = FlushReq ? FLUSH : RUN;
      default: state_d = RUN;
    endcase
  end

  // Output and datapath logic
  always_comb begin
    // A flush request in RUN blocks that cycle's grant and release.
    run_go   = (state_q == RUN) && !FlushReq;
    grant_ok = run_go && !FlEmpty && ({1'b0, inflight_q} < TAG_LIMIT);

    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (grant_ok) begin
      if (!ptr_q) begin
        if (Req0Valid)      gnt0 = 1'b1;
        else if (Req1Valid) gnt1 = 1'b1;
      end else begin
        if (Req1Valid)      gnt1 = 1'b1;
        else if (Req0Valid) gnt0 = 1'b1;
      end
    end

    rel_ok  = run_go && RelValid && !FlFull && (inflight_q != '0);
    rel_bad = run_go && RelValid && !rel_ok;

    ptr_d = ptr_q;
    if (gnt0)      ptr_d = 1'b1;
    else if (gnt1) ptr_d = 1'b0;

    inflight_d = inflight_q;
    if (state_q == FLUSH) begin
      inflight_d = '0;
    end else if ((gnt0 || gnt1) && !rel_ok) begin
      inflight_d = inflight_q + 3'd1;
    end else if (!(gnt0 || gnt1) && rel_ok) begin
      inflight_d = inflight_q - 3'd1;
    end

    err_d = err_q | rel_bad;

    // Strobes are gated by Rest so nothing fires while reset is held.
    Req0Ready = gnt0 & Rest;
    Req1Ready = gnt1 & Rest;
    FlRable   = (gnt0 | gnt1) & Rest;
    FlWable   = rel_ok & Rest;
    FlClean   = (state_q == FLUSH) & Rest;
    FlushBusy = (state_q != RUN);
    GntTag    = FlPreOut;
    FlDin     = RelTag;
    InFlight  = inflight_q;
    ErrRel    = err_q;
  end

endmodule
